seven_seg_scan_driver: RTL and testbench
========================================

Name: seven_seg_scan_driver

Overview:
- Parametrised, time-multiplexed hex display driver for NUM_DIGITS common-anode seven-segment digits (Basys3-class boards).
- Replaces the switch-selected, single-digit decoder. An internal refresh counter scans every digit.
- Per-digit blanking and decimal points.
- Tear-free double-buffered updates: new data is applied only at frame boundaries.

Parameters:
- NUM_DIGITS, 4, number of digits/anodes scanned; legal range 1..8.
- REFRESH_DIV, 100000, clk cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 2, anti-ghosting dead time at the start of each slot, in cycles; legal range 0..REFRESH_DIV-1.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- value  in  4*NUM_DIGITS  hex nibbles; digit i uses value[4i+3:4i], digit 0 is rightmost.
- dp  in  NUM_DIGITS  decimal point request per digit, active-high.
- digit_en  in  NUM_DIGITS  per-digit enable; 0 blanks the digit.
- load  in  1  one-cycle strobe that captures value/dp/digit_en into the pending buffer.
- update_pending  out  1  high from the load capture until the pending buffer is copied to the active buffer.
- seg  out  [0:6]  segments a..g, active-low, seg[0]=a.
- dp_n  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  anodes, active-low; an[i] drives digit i.
- frame_tick  out  1  one-cycle pulse each time the scan wraps from digit NUM_DIGITS-1 to digit 0.

Behaviour:
- Reset state (rst_n low at a clk edge):
  - prescaler=0, idx=0, pending and active buffers all 0 (so every digit is blanked), update_pending=0.
  - Outputs: an all 1, seg=7'b1111111, dp_n=1, frame_tick=0.
- Reset asserted mid-scan or mid-update abandons any pending load.
- Prescaler:
  - Width is $clog2(REFRESH_DIV). Counts 0..REFRESH_DIV-1, then wraps to 0.
  - At terminal count REFRESH_DIV-1, idx advances. idx wraps from NUM_DIGITS-1 to 0.
- frame_tick: asserted in the cycle immediately after the idx wrap, for exactly one cycle. Period is NUM_DIGITS*REFRESH_DIV cycles.
- Load handshake:
  - load=1 at an edge overwrites the pending buffer with the inputs and sets update_pending=1.
  - Back-to-back loads: the last one wins.
- Frame boundary, i.e. the cycle where idx wraps to 0:
  - If update_pending=1, the pending buffer is copied to the active buffer and update_pending clears.
  - Simultaneous load and wrap: the active buffer takes the prior pending contents. The new load data goes to pending and update_pending stays 1 for the next frame.
  - If update_pending=1 but no load occurred since the last copy, this case cannot arise.
- Output stage (registered, one-cycle latency from prescaler/idx):
  - If prescaler < BLANK_CYCLES, all of an=1. seg and dp_n are still driven for the current idx.
  - Otherwise, an = all 1 except an[idx]=0.
  - seg = hex glyph of active nibble idx; if the active digit_en[idx]=0, seg=7'b1111111.
  - dp_n = ~(active dp[idx] & active digit_en[idx]).
- Glyph codes (abcdefg, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- NUM_DIGITS=1: idx stays 0 and frame_tick pulses every REFRESH_DIV cycles.

Optional Feature:
- Macro: SEVEN_SEG_LZ_BLANK_EN.
- Defined:
  - Leading-zero suppression on the active buffer. Scanning from digit NUM_DIGITS-1 downward, each digit whose nibble is 0 and whose dp is 0 is blanked.
  - Suppression stops at the first nonzero nibble or set dp. Digit 0 is never suppressed.
  - Suppression is ANDed with digit_en.
- Undefined: every enabled digit is displayed, including leading zeros.

Decomposition:
- Package seven_seg_pkg holds:
  - the 16 glyph constants;
  - SEG_BLANK=7'b1111111;
  - the function hex_to_seg(nibble).
- One combinational sub-module, seven_seg_hex_decoder (4-bit nibble -> [0:6] seg), built on hex_to_seg and instantiated once on the selected nibble.

Test Plan:
- Test configuration: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
- Reset: hold rst_n=0 for 3 clk, release -> an=4'b1111, seg=7'b1111111, dp_n=1, update_pending=0. First frame_tick follows 16 cycles after release.
- Scan: load value=16'h12AF, digit_en=4'hF, dp=4'b0100 -> update_pending clears at the next wrap. Next frame shows, in order:
  - an 1110 with seg 0111000 (F);
  - an 1101 with seg 0001000 (A);
  - an 1011 with seg 0010010 (2) and dp_n=0;
  - an 0111 with seg 1001111 (1).
  - Each slot has one all-off cycle, then 3 active cycles.
- Blanking: digit_en=4'b1010 -> slots 0 and 2 give seg=1111111 and dp_n=1 even when dp is set.
- Tear-free: load value=16'h0000 mid-frame -> the current frame still shows 12AF; the change appears only after frame_tick; update_pending is high between the two.
- Collision: load in the exact wrap cycle -> active takes the earlier pending data, update_pending stays 1, and the new data appears one frame later.
- With SEVEN_SEG_LZ_BLANK_EN defined: value=16'h0050, dp=0 -> digits 3 and 2 blank, digit 1 shows 5, digit 0 shows 0. With dp[3]=1, no digit is suppressed.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - glyph table and nibble-to-segment helper for the scan driver
package seven_seg_pkg;

    // Segment order is a..g from index 0; all glyphs are active-low.
    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b0100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0000100;
    localparam logic [0:6] SEG_A     = 7'b0001000;
    localparam logic [0:6] SEG_B     = 7'b1100000;
    localparam logic [0:6] SEG_C     = 7'b0110001;
    localparam logic [0:6] SEG_D     = 7'b1000010;
    localparam logic [0:6] SEG_E     = 7'b0110000;
    localparam logic [0:6] SEG_F     = 7'b0111000;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    function automatic logic [0:6] hex_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'h0:    return SEG_0;
            4'h1:    return SEG_1;
            4'h2:    return SEG_2;
            4'h3:    return SEG_3;
            4'h4:    return SEG_4;
            4'h5:    return SEG_5;
            4'h6:    return SEG_6;
            4'h7:    return SEG_7;
            4'h8:    return SEG_8;
            4'h9:    return SEG_9;
            4'hA:    return SEG_A;
            4'hB:    return SEG_B;
            4'hC:    return SEG_C;
            4'hD:    return SEG_D;
            4'hE:    return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_hex_decoder.sv
// rtl/seven_seg_hex_decoder.sv - combinational hex nibble to active-low segment decoder
module seven_seg_hex_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [0:6] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - multiplexed hex display driver with frame-synchronous double buffering
// Optional leading-zero suppression: define SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic                    update_pending,
    output logic [0:6]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_P  = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]         prescaler;
    logic [IW-1:0]         idx;
    logic                  slot_end;
    logic                  frame_wrap;
    logic                  in_blank;

    logic [VW-1:0]         pend_value, act_value;
    logic [NUM_DIGITS-1:0] pend_dp, act_dp;
    logic [NUM_DIGITS-1:0] pend_en, act_en;
    logic [NUM_DIGITS-1:0] eff_en;

    logic [3:0]            sel_nibble;
    logic                  sel_dp;
    logic                  sel_en;
    logic [0:6]            dec_seg;

    assign slot_end   = (prescaler == PRE_LAST);
    assign frame_wrap = slot_end && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler  <= '0;
            idx        <= '0;
            frame_tick <= 1'b0;
        end else begin
            prescaler  <= slot_end ? '0 : prescaler + 1'b1;
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            frame_tick <= frame_wrap;
        end
    end

    // Active takes the old pending contents even when a load lands on the wrap edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_value     <= '0;
            pend_dp        <= '0;
            pend_en        <= '0;
            act_value      <= '0;
            act_dp         <= '0;
            act_en         <= '0;
            update_pending <= 1'b0;
        end else begin
            if (load) begin
                pend_value <= value;
                pend_dp    <= dp;
                pend_en    <= digit_en;
            end
            if (frame_wrap && update_pending) begin
                act_value <= pend_value;
                act_dp    <= pend_dp;
                act_en    <= pend_en;
            end
            update_pending <= load | (update_pending & ~frame_wrap);
        end
    end

`ifdef SEVEN_SEG_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_keep;
    logic                  lz_run;

    always_comb begin
        lz_keep = '1;
        lz_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lz_run && (act_value[4*i +: 4] == 4'h0) && !act_dp[i]) begin
                lz_keep[i] = 1'b0;
            end else begin
                lz_run = 1'b0;
            end
        end
    end

    assign eff_en = act_en & lz_keep;
`else
    assign eff_en = act_en;
`endif

    always_comb begin
        sel_nibble = 4'h0;
        sel_dp     = 1'b0;
        sel_en     = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                sel_nibble = act_value[4*i +: 4];
                sel_dp     = act_dp[i];
                sel_en     = eff_en[i];
            end
        end
    end

    generate
        if (BLANK_CYCLES == 0) begin : g_no_dead
            assign in_blank = 1'b0;
        end else begin : g_dead
            assign in_blank = (prescaler < BLANK_P);
        end
    endgenerate

    seven_seg_hex_decoder u_dec (
        .nibble (sel_nibble),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an   <= '1;
            seg  <= SEG_BLANK;
            dp_n <= 1'b1;
        end else begin
            an   <= in_blank ? '1 : ~(NUM_DIGITS'(1) << idx);
            seg  <= sel_en ? dec_seg : SEG_BLANK;
            dp_n <= ~(sel_dp & sel_en);
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - directed self-checking bench for seven_seg_scan_driver
module tb_seven_seg_scan_driver;

    localparam logic [0:6] G_0  = 7'b0000001;
    localparam logic [0:6] G_1  = 7'b1001111;
    localparam logic [0:6] G_2  = 7'b0010010;
    localparam logic [0:6] G_3  = 7'b0000110;
    localparam logic [0:6] G_4  = 7'b1001100;
    localparam logic [0:6] G_5  = 7'b0100100;
    localparam logic [0:6] G_A  = 7'b0001000;
    localparam logic [0:6] G_F  = 7'b0111000;
    localparam logic [0:6] G_BL = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic        load;
    logic        update_pending;
    logic [0:6]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_tick;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [0:6] exp_g [4];
    logic [3:0] exp_dpn;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .value          (value),
        .dp             (dp),
        .digit_en       (digit_en),
        .load           (load),
        .update_pending (update_pending),
        .seg            (seg),
        .dp_n           (dp_n),
        .an             (an),
        .frame_tick     (frame_tick)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_expect(input logic [0:6] g0, input logic [0:6] g1,
                              input logic [0:6] g2, input logic [0:6] g3,
                              input logic [3:0] dpn);
        exp_g[0] = g0;
        exp_g[1] = g1;
        exp_g[2] = g2;
        exp_g[3] = g3;
        exp_dpn  = dpn;
    endtask

    // Sample k of a frame: slot k/4, first cycle of each slot has every anode off.
    task automatic check_sample(input int k);
        int         slot;
        logic [3:0] exp_an;
        slot   = k / 4;
        exp_an = ((k % 4) == 0) ? 4'b1111 : ~(4'b0001 << slot);
        check($sformatf("an k%0d", k), 16'(an), 16'(exp_an));
        check($sformatf("seg k%0d", k), 16'(seg), 16'(exp_g[slot]));
        check($sformatf("dp_n k%0d", k), 16'(dp_n), 16'(exp_dpn[slot]));
        check($sformatf("frame_tick k%0d", k), 16'(frame_tick), 16'(k == 15));
    endtask

    task automatic check_frame();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check_sample(k);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        value    = v;
        dp       = d;
        digit_en = e;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 40);
        if (!frame_tick) check("frame_tick timeout", 16'(n), 16'd0);
    endtask

    initial begin
        int cnt;
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = '0;
        dp       = '0;
        digit_en = '0;
        repeat (3) @(negedge clk);
        check("reset an", 16'(an), 16'hF);
        check("reset seg", 16'(seg), 16'(G_BL));
        check("reset dp_n", 16'(dp_n), 16'd1);
        check("reset update_pending", 16'(update_pending), 16'd0);
        check("reset frame_tick", 16'(frame_tick), 16'd0);

        rst_n = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!frame_tick && cnt < 100);
        check("first frame_tick latency", 16'(cnt), 16'd16);

        // Basic scan of 12AF with dp on digit 2
        do_load(16'h12AF, 4'b0100, 4'hF);
        check("pending after load", 16'(update_pending), 16'd1);
        wait_tick();
        check("pending cleared at wrap", 16'(update_pending), 16'd0);
        set_expect(G_F, G_A, G_2, G_1, 4'b1011);
        check_frame();

        // Disabled digits blank segments and dp
        do_load(16'h12AF, 4'b0101, 4'b1010);
        wait_tick();
        set_expect(G_BL, G_A, G_BL, G_1, 4'b1111);
        check_frame();

        // Tear-free: mid-frame load does not disturb the frame in progress
        do_load(16'h12AF, 4'b0100, 4'hF);
        wait_tick();
        set_expect(G_F, G_A, G_2, G_1, 4'b1011);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check_sample(k);
            if (k == 5) begin
                value    = 16'h0000;
                dp       = 4'b0000;
                digit_en = 4'hF;
                load     = 1'b1;
            end else begin
                load = 1'b0;
            end
            if (k == 10) check("pending mid-frame", 16'(update_pending), 16'd1);
        end
        check("pending after tear-free wrap", 16'(update_pending), 16'd0);
        set_expect(G_0, G_0, G_0, G_0, 4'b1111);
        check_frame();

        // Collision: second load lands on the wrap edge
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            load = 1'b0;
            if (k == 2) begin
                value = 16'h3333;
                load  = 1'b1;
            end
            if (k == 14) begin
                value = 16'h4444;
                load  = 1'b1;
            end
        end
        @(negedge clk);
        load = 1'b0;
        check("collision frame_tick", 16'(frame_tick), 16'd1);
        check("collision pending held", 16'(update_pending), 16'd1);
        set_expect(G_3, G_3, G_3, G_3, 4'b1111);
        check_frame();
        check("collision pending cleared", 16'(update_pending), 16'd0);
        set_expect(G_4, G_4, G_4, G_4, 4'b1111);
        check_frame();

`ifdef SEVEN_SEG_LZ_BLANK_EN
        do_load(16'h0050, 4'b0000, 4'hF);
        wait_tick();
        set_expect(G_0, G_5, G_BL, G_BL, 4'b1111);
        check_frame();
        do_load(16'h0050, 4'b1000, 4'hF);
        wait_tick();
        set_expect(G_0, G_5, G_0, G_0, 4'b0111);
        check_frame();
`endif

        // Reset abandons a pending load
        do_load(16'h5555, 4'b0000, 4'hF);
        check("pending before reset", 16'(update_pending), 16'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset drops pending", 16'(update_pending), 16'd0);
        check("reset mid-scan an", 16'(an), 16'hF);
        check("reset mid-scan seg", 16'(seg), 16'(G_BL));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
